control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 149 ++++++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for an RV32-style core: owns the PC and instruction register
// and steps FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK], trapping on illegal opcodes.
module control_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] target_addr,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            rf_we,
  output logic            illegal,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd7
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic            legal;
  logic            is_store;
  logic            is_jump;
  logic [XLEN-1:0] pc_plus4;

  assign opcode   = instr_q[6:0];
  assign is_store = (opcode == OpStore);
  assign is_jump  = (opcode == OpJal) || (opcode == OpJalr);
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore,
      OpOpImm, OpOp, OpFence, OpSystem: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExecute;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StExecute: begin
        if ((opcode == OpLoad) || is_store) begin
          state_d = StMemory;
        end else if (opcode == OpBranch) begin
          state_d = StFetch;
          pc_d    = branch_taken ? target_addr : pc_plus4;
        end else if ((opcode == OpFence) || (opcode == OpSystem)) begin
          state_d = StFetch;
          pc_d    = pc_plus4;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        if (dmem_ack) begin
          if (is_store) begin
            state_d = StFetch;
            pc_d    = pc_plus4;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        state_d = StFetch;
        // Jump targets are forced to even addresses, matching JALR's LSB clear.
        pc_d    = is_jump ? {target_addr[XLEN-1:1], 1'b0} : pc_plus4;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them immediately.
  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == StMemory);
  assign dmem_we   = (state_q == StMemory) && is_store;
  assign rf_we     = (state_q == StWriteback);
  assign illegal   = illegal_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instruction streams
// compared against a per-instruction phase model built from the latency rules.
module tb_control_sequencer;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        branch_taken;
  logic [31:0] target_addr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        rf_we;
  logic        illegal;
  logic [2:0]  state_out;

  int          n_checks;
  int          n_errors;
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic [6:0]  legal_ops [11];

  control_sequencer #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .branch_taken (branch_taken),
    .target_addr  (target_addr),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .rf_we        (rf_we),
    .illegal      (illegal),
    .state_out    (state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_instr", instr_out, 32'h0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd1);
  endtask

  // Called at a falling edge; reset is asserted mid-cycle and released on the next falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n       = 1'b1;
    model_pc    = RESET_PC;
    model_instr = 32'h0;
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_imem_addr", imem_addr, RESET_PC);
  endtask

  // Runs one instruction: iw fetch wait cycles, dw memory wait cycles. Expected per-cycle state
  // comes from the phase list the latency rules imply; the next PC from the instruction class.
  task automatic run_instr(input logic [31:0] word, input int iw, input int dw,
                           input logic bt, input logic [31:0] tgt);
    logic [6:0]  opc;
    int          phases [$];
    logic [31:0] exp_pc;
    int          fc;
    int          mc;
    logic        writes_rf;
    opc       = word[6:0];
    writes_rf = (opc == OpLoad) || (opc == OpLui) || (opc == OpAuipc) || (opc == OpJal) ||
                (opc == OpJalr) || (opc == OpOpImm) || (opc == OpOp);
    for (int i = 0; i <= iw; i++) phases.push_back(0);
    phases.push_back(1);
    phases.push_back(2);
    if ((opc == OpLoad) || (opc == OpStore)) begin
      for (int i = 0; i <= dw; i++) phases.push_back(3);
    end
    if (writes_rf) phases.push_back(4);

    if (opc == OpBranch) exp_pc = bt ? tgt : model_pc + 32'd4;
    else if ((opc == OpJal) || (opc == OpJalr)) exp_pc = tgt & 32'hFFFF_FFFE;
    else exp_pc = model_pc + 32'd4;

    branch_taken = bt;
    target_addr  = tgt;
    fc = 0;
    mc = 0;
    foreach (phases[k]) begin
      check("state", 32'(state_out), 32'(phases[k]));
      check("imem_req", 32'(imem_req), 32'(phases[k] == 0));
      check("dmem_req", 32'(dmem_req), 32'(phases[k] == 3));
      check("dmem_we", 32'(dmem_we), 32'((phases[k] == 3) && (opc == OpStore)));
      check("rf_we", 32'(rf_we), 32'(phases[k] == 4));
      check("pc_stable", pc_out, model_pc);
      check("instr", instr_out, (phases[k] == 0) ? model_instr : word);
      if (phases[k] == 0) begin
        check("imem_addr", imem_addr, model_pc);
        imem_ack   = (fc == iw);
        imem_rdata = (fc == iw) ? word : $urandom;
        fc++;
      end else begin
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
      end
      if (phases[k] == 3) begin
        dmem_ack = (mc == dw);
        mc++;
      end else begin
        dmem_ack = 1'($urandom);
      end
      @(negedge clk);
    end
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    model_pc    = exp_pc;
    model_instr = word;
    check("next_pc", pc_out, model_pc);
    check("instr_latched", instr_out, word);
    check("back_to_fetch", 32'(state_out), 32'd0);
  endtask

  task automatic run_trap(input logic [31:0] word);
    check("trap_fetch_state", 32'(state_out), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    check("trap_decode_state", 32'(state_out), 32'd1);
    check("trap_decode_illegal", 32'(illegal), 32'd0);
    imem_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("trap_state", 32'(state_out), 32'd7);
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_imem_req", 32'(imem_req), 32'd0);
      check("trap_dmem_req", 32'(dmem_req), 32'd0);
      check("trap_rf_we", 32'(rf_we), 32'd0);
      check("trap_pc", pc_out, model_pc);
      check("trap_instr", instr_out, word);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      dmem_ack   = 1'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    n_checks     = 0;
    n_errors     = 0;
    legal_ops    = '{OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore,
                     OpOpImm, OpOp, OpFence, OpSystem};
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    dmem_ack     = 1'b0;
    branch_taken = 1'b0;
    target_addr  = 32'h0;
    model_pc     = RESET_PC;
    model_instr  = 32'h0;

    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    check("first_imem_req", 32'(imem_req), 32'd1);
    check("first_imem_addr", imem_addr, RESET_PC);

    // addi at zero wait, then imem_addr must be 4
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    check("addi_next_addr", imem_addr, 32'h4);
    // load with two dmem wait cycles
    run_instr(32'h0000_A103, 0, 2, 1'b0, 32'h0);
    check("load_pc", pc_out, 32'h8);
    // branch at pc=8 taken, then jump back to 8 and branch not taken
    run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40);
    check("branch_taken_addr", imem_addr, 32'h40);
    run_instr(32'h0000_006F, 1, 0, 1'b0, 32'h8);
    run_instr(32'h0000_0063, 0, 0, 1'b0, 32'h40);
    check("branch_not_taken_addr", imem_addr, 32'hC);
    // jalr target LSB clear, then wrap from top of address space
    run_instr(32'h0000_8067, 0, 0, 1'b0, 32'h101);
    check("jalr_pc", pc_out, 32'h100);
    run_instr(32'h0000_8067, 0, 0, 1'b0, 32'hFFFF_FFFD);
    run_instr(32'h0050_0093, 2, 0, 1'b0, 32'h0);
    check("wrap_pc", pc_out, 32'h0);
    // store with one dmem wait, fence, system
    run_instr(32'h0020_A023, 0, 1, 1'b0, 32'h0);
    run_instr(32'h0000_000F, 0, 0, 1'b1, 32'h80);
    run_instr(32'h0000_0073, 1, 0, 1'b1, 32'h80);

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      w = {r[31:7], legal_ops[$urandom_range(0, 10)]};
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom);
    end

    // reset while in MEMORY with dmem_ack arriving in that same cycle
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_A103;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mem_abort_in_mem", 32'(state_out), 32'd3);
    dmem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("mem_abort_state", 32'(state_out), 32'd0);
    check("mem_abort_pc", pc_out, RESET_PC);
    check("mem_abort_rf_we", 32'(rf_we), 32'd0);
    check("mem_abort_dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    dmem_ack    = 1'b0;
    rst_n       = 1'b1;
    model_pc    = RESET_PC;
    model_instr = 32'h0;
    @(negedge clk);
    check("mem_abort_after_state", 32'(state_out), 32'd0);
    check("mem_abort_after_rf_we", 32'(rf_we), 32'd0);
    check("mem_abort_after_pc", pc_out, RESET_PC);
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);

    // illegal opcode traps until reset
    run_trap(32'hFFFF_FFFF);
    do_reset();
    run_instr(32'h0050_0093, 1, 0, 1'b0, 32'h0);
    check("post_trap_pc", pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
